axi_mem_master: RTL and testbench

AXI_MEM_MASTER -- requirements
Module: axi_mem_master

---
 rtl/axi_mem_master_if.sv | 97 +++++++++
 rtl/axi_mem_master.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_mem_master.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_master_if.sv
// ---------------------------------------------------------------------------
// axi_mem_master_if
// Bundles the core request/response handshake and the five AXI4 channels used
// by axi_mem_master.
//   master modport : view of the memory master (drives req_ready, rsp_*, AW/W/AR
//                    valids and fields, B/R readies)
//   slave modport  : the opposite view (core + AXI responder side)
// Signal names follow the AXI channel naming (_o = driven by the master,
// _i = driven toward the master).
// ---------------------------------------------------------------------------
interface axi_mem_master_if #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
);
  // core side
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_wen;
  logic [AXI_ADDR_WIDTH-1:0]   req_addr;
  logic [1:0]                  req_size;
  logic [AXI_DATA_WIDTH-1:0]   req_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb;
  logic [AXI_ID_WIDTH-1:0]     req_id;
  logic                        rsp_valid;
  logic                        rsp_err;
  logic [AXI_DATA_WIDTH-1:0]   rsp_rdata;

  // AW
  logic                        axi_aw_valid_o;
  logic                        axi_aw_ready_i;
  logic [AXI_ID_WIDTH-1:0]     axi_aw_id_o;
  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_o;
  logic [7:0]                  axi_aw_len_o;
  logic [2:0]                  axi_aw_size_o;
  logic [1:0]                  axi_aw_burst_o;
  // W
  logic                        axi_w_valid_o;
  logic                        axi_w_ready_i;
  logic [AXI_DATA_WIDTH-1:0]   axi_w_data_o;
  logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_o;
  logic                        axi_w_last_o;
  // B
  logic                        axi_b_ready_o;
  logic                        axi_b_valid_i;
  logic [AXI_ID_WIDTH-1:0]     axi_b_id_i;
  logic [1:0]                  axi_b_resp_i;
  // AR
  logic                        axi_ar_valid_o;
  logic                        axi_ar_ready_i;
  logic [AXI_ID_WIDTH-1:0]     axi_ar_id_o;
  logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_o;
  logic [7:0]                  axi_ar_len_o;
  logic [2:0]                  axi_ar_size_o;
  logic [1:0]                  axi_ar_burst_o;
  // R
  logic                        axi_r_ready_o;
  logic                        axi_r_valid_i;
  logic [AXI_ID_WIDTH-1:0]     axi_r_id_i;
  logic [1:0]                  axi_r_resp_i;
  logic [AXI_DATA_WIDTH-1:0]   axi_r_data_i;
  logic                        axi_r_last_i;

  modport master (
    input  req_valid, req_wen, req_addr, req_size, req_wdata, req_wstrb, req_id,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output axi_aw_valid_o, axi_aw_id_o, axi_aw_addr_o, axi_aw_len_o,
           axi_aw_size_o, axi_aw_burst_o,
    input  axi_aw_ready_i,
    output axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o,
    input  axi_w_ready_i,
    output axi_b_ready_o,
    input  axi_b_valid_i, axi_b_id_i, axi_b_resp_i,
    output axi_ar_valid_o, axi_ar_id_o, axi_ar_addr_o, axi_ar_len_o,
           axi_ar_size_o, axi_ar_burst_o,
    input  axi_ar_ready_i,
    output axi_r_ready_o,
    input  axi_r_valid_i, axi_r_id_i, axi_r_resp_i, axi_r_data_i, axi_r_last_i
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_size, req_wdata, req_wstrb, req_id,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  axi_aw_valid_o, axi_aw_id_o, axi_aw_addr_o, axi_aw_len_o,
           axi_aw_size_o, axi_aw_burst_o,
    output axi_aw_ready_i,
    input  axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o,
    output axi_w_ready_i,
    input  axi_b_ready_o,
    output axi_b_valid_i, axi_b_id_i, axi_b_resp_i,
    input  axi_ar_valid_o, axi_ar_id_o, axi_ar_addr_o, axi_ar_len_o,
           axi_ar_size_o, axi_ar_burst_o,
    output axi_ar_ready_i,
    input  axi_r_ready_o,
    output axi_r_valid_i, axi_r_id_i, axi_r_resp_i, axi_r_data_i, axi_r_last_i
  );
endinterface

// File: rtl/axi_mem_master.sv
// ---------------------------------------------------------------------------
// axi_mem_master
// Converts single core load/store requests into single-beat AXI4 transactions
// (len 0, size 8 bytes, INCR), one transaction outstanding at a time.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous, active-high reset
//   bus  : axi_mem_master_if.master -- core req/rsp handshake + AW/W/B/AR/R
// Optional feature: define AXI_MEM_MASTER_ALIGN_CHECK_EN to reject requests
// whose address is not aligned to the access size; such requests complete
// with rsp_err=1 and generate no AXI traffic.
//
// state | meaning
// IDLE  | waiting for a core request (req_ready=1)
// RD_A  | AR valid, waiting for ar_ready
// RD_D  | R ready, waiting for the single read beat
// WR_A  | AW and W presented, each retired independently
// WR_B  | B ready, waiting for write response
// RESP  | one-cycle rsp_valid pulse back to the core
// ---------------------------------------------------------------------------
module axi_mem_master #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  axi_mem_master_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_D = 3'd2,
    WR_A = 3'd3,
    WR_B = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;

  logic [AXI_ADDR_WIDTH-1:3]     r_addr;
  logic [AXI_DATA_WIDTH-1:0]     r_wdata;
  logic [AXI_DATA_WIDTH/8-1:0]   r_wstrb;
  logic [AXI_ID_WIDTH-1:0]       r_id;
  logic                          r_aw_done;
  logic                          r_w_done;
  logic [AXI_DATA_WIDTH-1:0]     r_rdata;
  logic                          r_err;

  logic w_req_ready;
  logic w_rsp_valid;
  logic w_ar_valid;
  logic w_aw_valid;
  logic w_w_valid;
  logic w_r_ready;
  logic w_b_ready;

  logic w_accept;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_r_hs;
  logic w_b_hs;
  logic w_misalign;

  assign w_accept = bus.req_valid & w_req_ready;
  assign w_aw_hs  = w_aw_valid & bus.axi_aw_ready_i;
  assign w_w_hs   = w_w_valid  & bus.axi_w_ready_i;
  assign w_r_hs   = w_r_ready  & bus.axi_r_valid_i;
  assign w_b_hs   = w_b_ready  & bus.axi_b_valid_i;

`ifdef AXI_MEM_MASTER_ALIGN_CHECK_EN
  // Access is at most 8 bytes, so only the low three address bits matter.
  logic [2:0] w_size_mask;
  always_comb begin
    w_size_mask = 3'b000;
    case (bus.req_size)
      2'd0:    w_size_mask = 3'b000;
      2'd1:    w_size_mask = 3'b001;
      2'd2:    w_size_mask = 3'b011;
      default: w_size_mask = 3'b111;
    endcase
  end
  assign w_misalign = |(bus.req_addr[2:0] & w_size_mask);
`else
  // Size and sub-word address bits are deliberately ignored in this build.
  logic w_unused_size;
  assign w_unused_size = ^{bus.req_size, bus.req_addr[2:0]};
  assign w_misalign    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_id      <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr    <= bus.req_addr[AXI_ADDR_WIDTH-1:3];
        r_wdata   <= bus.req_wdata;
        r_wstrb   <= bus.req_wstrb;
        r_id      <= bus.req_id;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        if (w_misalign) begin
          r_err <= 1'b1;
        end
      end
      if (w_aw_hs) begin
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_w_done <= 1'b1;
      end
      if (w_r_hs) begin
        r_rdata <= bus.axi_r_data_i;
        r_err   <= (bus.axi_r_resp_i != 2'b00) | ~bus.axi_r_last_i |
                   (bus.axi_r_id_i != r_id);
      end
      if (w_b_hs) begin
        r_err <= (bus.axi_b_resp_i != 2'b00) | (bus.axi_b_id_i != r_id);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_ar_valid  = 1'b0;
    w_aw_valid  = 1'b0;
    w_w_valid   = 1'b0;
    w_r_ready   = 1'b0;
    w_b_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        // Held low while rst is asserted so nothing is accepted during reset.
        w_req_ready = ~rst;
        if (bus.req_valid & ~rst) begin
          if (w_misalign) begin
            w_state_nxt = RESP;
          end else if (bus.req_wen) begin
            w_state_nxt = WR_A;
          end else begin
            w_state_nxt = RD_A;
          end
        end
      end
      RD_A: begin
        w_ar_valid = 1'b1;
        if (bus.axi_ar_ready_i) begin
          w_state_nxt = RD_D;
        end
      end
      RD_D: begin
        w_r_ready = 1'b1;
        if (bus.axi_r_valid_i) begin
          w_state_nxt = RESP;
        end
      end
      WR_A: begin
        w_aw_valid = ~r_aw_done;
        w_w_valid  = ~r_w_done;
        // Both channels may retire on the same edge.
        if ((r_aw_done | (~r_aw_done & bus.axi_aw_ready_i)) &
            (r_w_done  | (~r_w_done  & bus.axi_w_ready_i))) begin
          w_state_nxt = WR_B;
        end
      end
      WR_B: begin
        w_b_ready = 1'b1;
        if (bus.axi_b_valid_i) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_rsp_valid = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.req_ready      = w_req_ready;
  assign bus.rsp_valid      = w_rsp_valid;
  assign bus.rsp_err        = r_err;
  assign bus.rsp_rdata      = r_rdata;

  assign bus.axi_aw_valid_o = w_aw_valid;
  assign bus.axi_aw_id_o    = r_id;
  assign bus.axi_aw_addr_o  = {r_addr, 3'b000};
  assign bus.axi_aw_len_o   = 8'd0;
  assign bus.axi_aw_size_o  = 3'd3;
  assign bus.axi_aw_burst_o = 2'b01;

  assign bus.axi_w_valid_o  = w_w_valid;
  assign bus.axi_w_data_o   = r_wdata;
  assign bus.axi_w_strb_o   = r_wstrb;
  assign bus.axi_w_last_o   = 1'b1;

  assign bus.axi_b_ready_o  = w_b_ready;

  assign bus.axi_ar_valid_o = w_ar_valid;
  assign bus.axi_ar_id_o    = r_id;
  assign bus.axi_ar_addr_o  = {r_addr, 3'b000};
  assign bus.axi_ar_len_o   = 8'd0;
  assign bus.axi_ar_size_o  = 3'd3;
  assign bus.axi_ar_burst_o = 2'b01;

  assign bus.axi_r_ready_o  = w_r_ready;

endmodule

// File: tb/tb_axi_mem_master.sv
// ---------------------------------------------------------------------------
// tb_axi_mem_master
// Directed bench for axi_mem_master: drives the core side and plays the AXI
// responder through the interface. Inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the active posedge.
// ---------------------------------------------------------------------------
module tb_axi_mem_master;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  axi_mem_master_if #(.AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(4)) bus ();

  axi_mem_master #(.AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Read against an always-ready, next-cycle responder; checks exact latency.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic [3:0] id, input logic [31:0] exp_ar_addr,
                         input logic [63:0] data, input logic [1:0] resp,
                         input logic [3:0] rid, input logic last, input logic exp_err);
    bus.axi_ar_ready_i = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b0;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_id    = id;
    check_val({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_val({tag, "_ar_valid"}, 64'(bus.axi_ar_valid_o), 64'd1);
    check_val({tag, "_ar_addr"}, 64'(bus.axi_ar_addr_o), 64'(exp_ar_addr));
    check_val({tag, "_ar_len"}, 64'(bus.axi_ar_len_o), 64'd0);
    check_val({tag, "_ar_size"}, 64'(bus.axi_ar_size_o), 64'd3);
    check_val({tag, "_ar_burst"}, 64'(bus.axi_ar_burst_o), 64'd1);
    check_val({tag, "_ar_id"}, 64'(bus.axi_ar_id_o), 64'(id));
    check_val({tag, "_r_ready_early"}, 64'(bus.axi_r_ready_o), 64'd0);
    @(negedge clk);
    check_val({tag, "_ar_valid_drop"}, 64'(bus.axi_ar_valid_o), 64'd0);
    check_val({tag, "_r_ready"}, 64'(bus.axi_r_ready_o), 64'd1);
    bus.axi_r_valid_i = 1'b1;
    bus.axi_r_data_i  = data;
    bus.axi_r_resp_i  = resp;
    bus.axi_r_id_i    = rid;
    bus.axi_r_last_i  = last;
    @(negedge clk);
    bus.axi_r_valid_i = 1'b0;
    check_val({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    check_val({tag, "_rdata"}, bus.rsp_rdata, data);
    check_val({tag, "_err"}, 64'(bus.rsp_err), 64'(exp_err));
    check_val({tag, "_r_ready_after"}, 64'(bus.axi_r_ready_o), 64'd0);
    @(negedge clk);
    check_val({tag, "_rsp_pulse_end"}, 64'(bus.rsp_valid), 64'd0);
    check_val({tag, "_req_ready_again"}, 64'(bus.req_ready), 64'd1);
  endtask

  // Write with w_ready always high and aw_ready raised after aw_delay cycles.
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [63:0] wdata,
                          input logic [7:0] wstrb, input logic [3:0] id, input int aw_delay,
                          input logic [1:0] bresp, input logic [3:0] bid,
                          input int exp_aw_cyc, input logic exp_err);
    int cnt_aw;
    int cnt_w;
    cnt_aw = 0;
    cnt_w  = 0;
    bus.axi_aw_ready_i = 1'b0;
    bus.axi_w_ready_i  = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b1;
    bus.req_addr  = addr;
    bus.req_size  = 2'd3;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
    bus.req_id    = id;
    check_val({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_val({tag, "_aw_addr"}, 64'(bus.axi_aw_addr_o), 64'(addr));
    check_val({tag, "_aw_len"}, 64'(bus.axi_aw_len_o), 64'd0);
    check_val({tag, "_aw_size"}, 64'(bus.axi_aw_size_o), 64'd3);
    check_val({tag, "_aw_burst"}, 64'(bus.axi_aw_burst_o), 64'd1);
    check_val({tag, "_aw_id"}, 64'(bus.axi_aw_id_o), 64'(id));
    check_val({tag, "_w_data"}, bus.axi_w_data_o, wdata);
    check_val({tag, "_w_strb"}, 64'(bus.axi_w_strb_o), 64'(wstrb));
    check_val({tag, "_w_last"}, 64'(bus.axi_w_last_o), 64'd1);
    for (int i = 0; i < 12; i++) begin
      if (bus.axi_b_ready_o) break;
      if (bus.axi_aw_valid_o) cnt_aw++;
      if (bus.axi_w_valid_o)  cnt_w++;
      bus.axi_aw_ready_i = (cnt_aw == aw_delay + 1);
      @(negedge clk);
    end
    bus.axi_aw_ready_i = 1'b0;
    check_val({tag, "_b_ready"}, 64'(bus.axi_b_ready_o), 64'd1);
    check_val({tag, "_aw_cycles"}, 64'(cnt_aw), 64'(exp_aw_cyc));
    check_val({tag, "_w_cycles"}, 64'(cnt_w), 64'd1);
    bus.axi_b_valid_i = 1'b1;
    bus.axi_b_resp_i  = bresp;
    bus.axi_b_id_i    = bid;
    @(negedge clk);
    bus.axi_b_valid_i = 1'b0;
    check_val({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    check_val({tag, "_err"}, 64'(bus.rsp_err), 64'(exp_err));
    check_val({tag, "_b_ready_after"}, 64'(bus.axi_b_ready_o), 64'd0);
    @(negedge clk);
    check_val({tag, "_rsp_pulse_end"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_ar_valid"}, 64'(bus.axi_ar_valid_o), 64'd0);
    check_val({tag, "_aw_valid"}, 64'(bus.axi_aw_valid_o), 64'd0);
    check_val({tag, "_w_valid"}, 64'(bus.axi_w_valid_o), 64'd0);
    check_val({tag, "_r_ready"}, 64'(bus.axi_r_ready_o), 64'd0);
    check_val({tag, "_b_ready"}, 64'(bus.axi_b_ready_o), 64'd0);
    check_val({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.req_id    = '0;
    bus.axi_aw_ready_i = 1'b0;
    bus.axi_w_ready_i  = 1'b0;
    bus.axi_b_valid_i  = 1'b0;
    bus.axi_b_id_i     = '0;
    bus.axi_b_resp_i   = '0;
    bus.axi_ar_ready_i = 1'b0;
    bus.axi_r_valid_i  = 1'b0;
    bus.axi_r_id_i     = '0;
    bus.axi_r_resp_i   = '0;
    bus.axi_r_data_i   = '0;
    bus.axi_r_last_i   = 1'b0;

    repeat (3) @(negedge clk);
    check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_quiet("rst");
    check_val("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check_val("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
    check_val("rst_ar_addr", 64'(bus.axi_ar_addr_o), 64'd0);
    check_val("rst_aw_id", 64'(bus.axi_aw_id_o), 64'd0);
    check_val("rst_w_data", bus.axi_w_data_o, 64'd0);
    check_val("rst_w_strb", 64'(bus.axi_w_strb_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_req_ready", 64'(bus.req_ready), 64'd1);

    // Stray response beats in IDLE must not be consumed.
    bus.axi_r_valid_i = 1'b1;
    bus.axi_b_valid_i = 1'b1;
    @(negedge clk);
    check_val("stray_r_ready", 64'(bus.axi_r_ready_o), 64'd0);
    check_val("stray_b_ready", 64'(bus.axi_b_ready_o), 64'd0);
    check_val("stray_idle", 64'(bus.req_ready), 64'd1);
    bus.axi_r_valid_i = 1'b0;
    bus.axi_b_valid_i = 1'b0;

    do_read("rd_basic", 32'h8000_0010, 2'd3, 4'd2, 32'h8000_0010,
            64'h1122_3344_5566_7788, 2'd0, 4'd2, 1'b1, 1'b0);

    do_write("wr_aw_delay", 32'h8000_0008, 64'h0000_0000_DEAD_BEEF, 8'h0F, 4'd3, 3,
             2'd0, 4'd3, 4, 1'b0);
    check_val("wr_keeps_rdata", bus.rsp_rdata, 64'h1122_3344_5566_7788);

    do_write("wr_same_cycle", 32'h8000_0100, 64'hA5A5_0000_1234_5678, 8'hFF, 4'd7, 0,
             2'd0, 4'd7, 1, 1'b0);
    do_write("wr_slverr", 32'h8000_0200, 64'h1, 8'h01, 4'd1, 1, 2'd2, 4'd1, 2, 1'b1);
    do_write("wr_bad_bid", 32'h8000_0208, 64'h2, 8'h02, 4'd1, 0, 2'd0, 4'd9, 1, 1'b1);

    do_read("rd_slverr", 32'h8000_0020, 2'd3, 4'd2, 32'h8000_0020,
            64'hCAFE_F00D_0000_0001, 2'd2, 4'd2, 1'b1, 1'b1);
    do_read("rd_bad_id", 32'h8000_0028, 2'd3, 4'd2, 32'h8000_0028,
            64'h0BAD_0000_0000_0005, 2'd0, 4'd5, 1'b1, 1'b1);
    do_read("rd_no_last", 32'h8000_0030, 2'd3, 4'd4, 32'h8000_0030,
            64'h0000_0000_0000_0042, 2'd0, 4'd4, 1'b0, 1'b1);
    do_read("rd_ok_after_err", 32'h8000_0038, 2'd3, 4'd6, 32'h8000_0038,
            64'h0123_4567_89AB_CDEF, 2'd0, 4'd6, 1'b1, 1'b0);

    // Reset while waiting in RD_D.
    bus.axi_ar_ready_i = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b0;
    bus.req_addr  = 32'h8000_0040;
    bus.req_size  = 2'd3;
    bus.req_id    = 4'd2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_val("mid_rst_in_rd_d", 64'(bus.axi_r_ready_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("mid_rst");
    check_val("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;
    bus.axi_r_valid_i = 1'b1;
    @(negedge clk);
    bus.axi_r_valid_i = 1'b0;
    check_quiet("mid_rst_after");
    check_val("mid_rst_rdata_cleared", bus.rsp_rdata, 64'd0);
    check_val("mid_rst_req_ready_back", 64'(bus.req_ready), 64'd1);
    do_read("rd_after_rst", 32'h8000_0048, 2'd3, 4'd2, 32'h8000_0048,
            64'hFEDC_BA98_7654_3210, 2'd0, 4'd2, 1'b1, 1'b0);

`ifdef AXI_MEM_MASTER_ALIGN_CHECK_EN
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b0;
    bus.req_addr  = 32'h8000_0002;
    bus.req_size  = 2'd2;
    bus.req_id    = 4'd2;
    check_val("misalign_req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_val("misalign_ar_valid", 64'(bus.axi_ar_valid_o), 64'd0);
    check_val("misalign_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check_val("misalign_err", 64'(bus.rsp_err), 64'd1);
    check_val("misalign_rdata_kept", bus.rsp_rdata, 64'hFEDC_BA98_7654_3210);
    @(negedge clk);
    check_val("misalign_rsp_end", 64'(bus.rsp_valid), 64'd0);
    check_val("misalign_no_ar", 64'(bus.axi_ar_valid_o), 64'd0);
    do_read("rd_aligned_w", 32'h8000_0004, 2'd2, 4'd2, 32'h8000_0000,
            64'h0000_0000_0000_0099, 2'd0, 4'd2, 1'b1, 1'b0);
`else
    do_read("rd_unaligned", 32'h8000_0002, 2'd2, 4'd2, 32'h8000_0000,
            64'h0000_0000_0000_0077, 2'd0, 4'd2, 1'b1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
